lpm_table_mem: RTL and testbench
================================

# lpm_table_mem

Pipelined lookup-table memory serving the LPM engine's memory interface: it accepts word-address read requests, returns table words in request order after a fixed latency, and buffers results until the engine accepts them. It sits directly downstream of the LPM stage's request/recirculation logic. It also exposes a table-load port used by the control path to program route entries.

## Interface

Parameters:
- ADDR_W, 10: table address width; the table holds 2^ADDR_W words.
- DATA_W, 32: table word width; must be 32 to match the engine's result path.
- LATENCY, 2: read pipeline depth in cycles, legal range 1..4.
- DEPTH, 4: maximum outstanding requests (in pipeline plus result buffer), at least LATENCY.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- ifc$req__ENA  in  1  read request strobe; asserted only while ifc$req__RDY=1.
- ifc$req$v  in  32  request word; bits [ADDR_W-1:0] are the table address, upper bits ignored.
- ifc$req__RDY  out  1  request accepted this cycle if ENA is high.
- ifc$resValue  out  DATA_W  head-of-buffer result word.
- ifc$resValue__RDY  out  1  result buffer non-empty.
- ifc$resAccept__ENA  in  1  pop head result; asserted only while RDY=1.
- ifc$resAccept__RDY  out  1  equal to ifc$resValue__RDY.
- load$write__ENA  in  1  table write strobe.
- load$write$addr  in  ADDR_W  write address.
- load$write$data  in  DATA_W  write data.
- load$write__RDY  out  1  write accepted if ENA is high.

## Operation

- The credit counter starts at DEPTH. A request decrements it and a resAccept increments it; both in the same cycle leave it unchanged. ifc$req__RDY = (credit != 0).
- Read pipeline: a valid/address shift register LATENCY stages long. The table array is read at stage 1. Data then travels with the valid bit and enters the result buffer when it leaves the last stage.
- Result buffer: a DEPTH-entry circular FIFO with wrapping read and write pointers and a count. The credit scheme guarantees it never overflows; overflow is an assertion failure.
- ifc$resValue shows the FIFO head. When the FIFO is empty it drives 0.
- A push and a pop in the same cycle leave the count unchanged. A push into an empty FIFO becomes visible the next cycle; there is no same-cycle bypass.
- Load port: load$write__RDY = (credit == DEPTH), so the table is written only while no request is outstanding. RDY never depends on any ENA.
- When a write and a request occur in the same cycle (possible only at credit == DEPTH), the read returns the old word and the write lands at the edge.
- Responses return strictly in request order.
- Reset clears the pipeline valids and FIFO pointers/count and sets credit to DEPTH. In-flight requests are discarded. Table contents are NOT cleared by reset; the array powers up undefined.

## Timing

Reset values of the outputs:
- ifc$req__RDY=1.
- ifc$resValue__RDY=0, ifc$resAccept__RDY=0.
- ifc$resValue=0.
- load$write__RDY=1.

Cycle behaviour:
- Latency: a request accepted at edge t sets ifc$resValue__RDY=1 in the cycle after edge t+LATENCY, provided the FIFO was empty.
- Throughput: one request per cycle while the consumer accepts every cycle.
- A sustained stall with no resAccept lets exactly DEPTH requests in, after which ifc$req__RDY=0.
- After an accept at edge t, ifc$req__RDY returns to 1 in the cycle after edge t.
- A write at edge t is visible to any request accepted at edge t+1 or later.
- RST asserted mid-operation: all outputs are at their reset values in the cycle after the edge.

## Structure

- Shared package `lpm_pkg` holds:
  - the `lpm_addr_t` and `lpm_word_t` typedefs;
  - the constant for the valid-flag bit (bit 0, which marks a leaf/final result in the engine);
  - the LATENCY legality check.
- Sub-module `lpm_result_fifo` is the parameterised DEPTH x DATA_W circular FIFO with count. The table array, pipeline and credit logic stay in the top block.

## Test plan

- Load then read: write 0x0000_0011 to addr 5, then request v=0x0001_0005 (upper bits ignored). With LATENCY=2, resValue__RDY rises exactly 2 cycles after the request and resValue=0x11.
- Back-to-back: write addr 0..3 = 0xA0..0xA3, then issue 4 consecutive requests with resAccept held high whenever RDY=1. Results 0xA0, 0xA1, 0xA2, 0xA3 appear on consecutive cycles, in order.
- Backpressure: DEPTH=4, no accepts. Exactly 4 requests are accepted, then req__RDY=0. One accept re-raises req__RDY the next cycle, and credit never exceeds 4.
- Simultaneous read/write: with the module idle and addr 7 holding 0x5, request addr 7 and write 0x9 to addr 7 in the same cycle. The response is 0x5, and a following read of addr 7 returns 0x9.
- Load blocking: with one request outstanding, load$write__RDY=0. It returns to 1 after the response is accepted.
- Reset mid-flight: issue 3 requests, then assert RST for one cycle. In the next cycle resValue__RDY=0 and req__RDY=1, no stale response ever emerges, and previously loaded table words still read back correctly.

Source files
------------

// File: rtl/lpm_pkg.sv
// Shared types and constants for the LPM engine memory path.
package lpm_pkg;

    localparam int unsigned LPM_ADDR_W    = 10;
    localparam int unsigned LPM_DATA_W    = 32;

    // Bit 0 of a table word flags a leaf entry, meaning the final result.
    localparam int unsigned LPM_VALID_BIT = 0;

    localparam int unsigned LPM_LAT_MIN   = 1;
    localparam int unsigned LPM_LAT_MAX   = 4;

    typedef logic [LPM_ADDR_W-1:0] lpm_addr_t;
    typedef logic [LPM_DATA_W-1:0] lpm_word_t;

    // Read pipeline depth must stay within the supported range.
    function automatic bit lpm_latency_ok(input int unsigned lat);
        return (lat >= LPM_LAT_MIN) && (lat <= LPM_LAT_MAX);
    endfunction

endpackage

// File: rtl/lpm_result_fifo.sv
// Circular result FIFO holding table words until the engine accepts them.
module lpm_result_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_pop;
    logic w_push;
    logic w_full;

    // Pointers wrap at DEPTH so non power-of-two depths work too.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

    // Pointer and occupancy tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Upstream credit accounting must never push into a full buffer.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && w_full && !w_pop));

endmodule

// File: rtl/lpm_table_mem.sv
// Pipelined lookup-table memory with credit flow control and a table-load port.
module lpm_table_mem
    import lpm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ifc_req__ENA,
    input  logic [31:0]       ifc_req_v,
    output logic              ifc_req__RDY,
    output logic [DATA_W-1:0] ifc_resValue,
    output logic              ifc_resValue__RDY,
    input  logic              ifc_resAccept__ENA,
    output logic              ifc_resAccept__RDY,
    input  logic              load_write__ENA,
    input  logic [ADDR_W-1:0] load_write_addr,
    input  logic [DATA_W-1:0] load_write_data,
    output logic              load_write__RDY
);

    localparam int unsigned CRED_W    = $clog2(DEPTH + 1);
    localparam int unsigned TBL_WORDS = 1 << ADDR_W;

    if (!lpm_latency_ok(LATENCY)) begin : g_bad_latency
        $error("lpm_table_mem: LATENCY must be 1..4");
    end
    if (DEPTH < LATENCY) begin : g_bad_depth
        $error("lpm_table_mem: DEPTH must be at least LATENCY");
    end
    if (DATA_W != LPM_DATA_W) begin : g_bad_width
        $error("lpm_table_mem: DATA_W must be 32");
    end

    logic [DATA_W-1:0] r_table [TBL_WORDS];
    logic [LATENCY-1:0] r_vld;
    logic [DATA_W-1:0]  r_pdata [LATENCY];
    logic [CRED_W-1:0]  r_credit;

    logic [ADDR_W-1:0] w_raddr;
    logic              w_unused_req_hi;
    logic              w_req_fire;
    logic              w_wr_fire;
    logic              w_pop;
    logic              w_fifo_valid;
    logic [DATA_W-1:0] w_fifo_data;

    assign w_raddr         = ifc_req_v[ADDR_W-1:0];
    assign w_unused_req_hi = ^ifc_req_v[31:ADDR_W];

    assign ifc_req__RDY       = (r_credit != '0);
    assign load_write__RDY    = (r_credit == CRED_W'(DEPTH));
    assign ifc_resValue__RDY  = w_fifo_valid;
    assign ifc_resAccept__RDY = w_fifo_valid;
    assign ifc_resValue       = w_fifo_data;

    assign w_req_fire = ifc_req__ENA && ifc_req__RDY;
    assign w_wr_fire  = load_write__ENA && load_write__RDY;
    assign w_pop      = ifc_resAccept__ENA && w_fifo_valid;

    // Credits cover every request from acceptance until its result is popped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_credit <= CRED_W'(DEPTH);
        end else if (w_req_fire && !w_pop) begin
            r_credit <= r_credit - CRED_W'(1);
        end else if (!w_req_fire && w_pop) begin
            r_credit <= r_credit + CRED_W'(1);
        end
    end

    // Valid shift register; reset drops any in-flight requests.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_req_fire;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Table array and data stages; a same-edge read sees the pre-write word.
    always_ff @(posedge CLK) begin
        if (w_wr_fire) r_table[load_write_addr] <= load_write_data;
        r_pdata[0] <= r_table[w_raddr];
        for (int i = 1; i < int'(LATENCY); i++) begin
            r_pdata[i] <= r_pdata[i-1];
        end
    end

    lpm_result_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_result_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (r_vld[LATENCY-1]),
        .i_data  (r_pdata[LATENCY-1]),
        .i_pop   (ifc_resAccept__ENA),
        .o_data  (w_fifo_data),
        .o_valid (w_fifo_valid)
    );

endmodule

// File: tb/tb_lpm_table_mem.sv
// Scoreboard bench for lpm_table_mem: driver pushes expectations, monitor pops on accept.
module tb_lpm_table_mem;
    import lpm_pkg::*;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned DEPTH   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_ena = 1'b0;
    logic [31:0]       req_v = '0;
    logic              req_rdy;
    logic [DATA_W-1:0] res_val;
    logic              res_rdy;
    logic              acc_ena = 1'b0;
    logic              acc_rdy;
    logic              wr_ena = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_rdy;

    always #5 clk = ~clk;

    lpm_table_mem #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .CLK                (clk),
        .RST                (rst),
        .ifc_req__ENA       (req_ena),
        .ifc_req_v          (req_v),
        .ifc_req__RDY       (req_rdy),
        .ifc_resValue       (res_val),
        .ifc_resValue__RDY  (res_rdy),
        .ifc_resAccept__ENA (acc_ena),
        .ifc_resAccept__RDY (acc_rdy),
        .load_write__ENA    (wr_ena),
        .load_write_addr    (wr_addr),
        .load_write_data    (wr_data),
        .load_write__RDY    (wr_rdy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_out    = 0;

    lpm_word_t         exp_q[$];
    int                pop_cyc[$];
    logic [DATA_W-1:0] ref_tbl [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: outstanding-count rules every cycle, response data on every accept.
    always @(negedge clk) begin
        cyc++;
        chk("req_rdy", 32'(req_rdy), 32'(m_out < int'(DEPTH)));
        chk("wr_rdy", 32'(wr_rdy), 32'(m_out == 0));
        chk("acc_rdy", 32'(acc_rdy), 32'(res_rdy));
        if (!res_rdy) chk("empty_value", res_val, 32'h0);
        if (acc_ena) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp: got %h expected no response (cycle %0d)", res_val, cyc);
            end else begin
                chk("resp", res_val, exp_q.pop_front());
            end
            pop_cyc.push_back(cyc);
        end
        if (rst) m_out = 0;
        else     m_out = m_out + int'(req_ena) - int'(acc_ena);
    end

    // One cycle of stimulus; called just after a rising edge.
    task automatic step(input bit do_req, input logic [31:0] v,
                        input bit do_wr, input logic [ADDR_W-1:0] wa, input logic [31:0] wd,
                        input bit do_acc, output bit fired);
        fired   = do_req && req_rdy;
        req_ena = fired;
        req_v   = v;
        if (fired) exp_q.push_back(ref_tbl[int'(v[ADDR_W-1:0])]);
        wr_ena  = do_wr && wr_rdy;
        wr_addr = wa;
        wr_data = wd;
        if (wr_ena) ref_tbl[int'(wa)] = wd;
        acc_ena = do_acc && res_rdy;
        @(posedge clk);
        #1;
        req_ena = 1'b0;
        wr_ena  = 1'b0;
        acc_ena = 1'b0;
    endtask

    task automatic idle(input bit do_acc);
        bit f;
        step(1'b0, 32'h0, 1'b0, '0, 32'h0, do_acc, f);
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bit f;
        step(1'b0, 32'h0, 1'b1, a, d, 1'b0, f);
    endtask

    task automatic read(input logic [31:0] v, input bit do_acc);
        bit f;
        step(1'b1, v, 1'b0, '0, 32'h0, do_acc, f);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (!(exp_q.size() == 0 && wr_rdy) && k < 40) begin
            idle(1'b1);
            k++;
        end
        chk(name, 32'(exp_q.size() == 0 && wr_rdy), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit f;
        int fired_cnt;
        logic [31:0] v;
        logic [ADDR_W-1:0] a;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_req_rdy", 32'(req_rdy), 32'h1);
        chk("rst_res_rdy", 32'(res_rdy), 32'h0);
        chk("rst_acc_rdy", 32'(acc_rdy), 32'h0);
        chk("rst_res_val", res_val, 32'h0);
        chk("rst_wr_rdy", 32'(wr_rdy), 32'h1);

        for (int i = 0; i < 16; i++) write(ADDR_W'(i), $urandom);

        // Load then read, latency check
        write(ADDR_W'(5), 32'h0000_0011);
        read(32'h0001_0005, 1'b0);
        chk("lat_edge0", 32'(res_rdy), 32'h0);
        idle(1'b0);
        chk("lat_edge1", 32'(res_rdy), 32'h0);
        idle(1'b0);
        chk("lat_edge2", 32'(res_rdy), 32'h1);
        chk("lat_value", res_val, 32'h0000_0011);
        drain("drain_lat");

        // Back-to-back with consumer always accepting
        for (int i = 0; i < 4; i++) write(ADDR_W'(i), 32'hA0 + 32'(i));
        pop_cyc.delete();
        for (int i = 0; i < 4; i++) read(32'(i), 1'b1);
        drain("drain_b2b");
        chk("b2b_pops", 32'(pop_cyc.size()), 32'h4);
        if (pop_cyc.size() == 4) chk("b2b_consecutive", 32'(pop_cyc[3] - pop_cyc[0]), 32'h3);

        // Backpressure: exactly DEPTH requests get in
        fired_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'(i), 1'b0, '0, 32'h0, 1'b0, f);
            fired_cnt += int'(f);
        end
        chk("bp_accepted", 32'(fired_cnt), 32'(DEPTH));
        chk("bp_req_rdy_low", 32'(req_rdy), 32'h0);
        idle(1'b1);
        chk("bp_req_rdy_back", 32'(req_rdy), 32'h1);
        read(32'h5, 1'b0);
        chk("bp_req_rdy_low2", 32'(req_rdy), 32'h0);
        drain("drain_bp");

        // Same-cycle read and write of one address
        write(ADDR_W'(7), 32'h5);
        step(1'b1, 32'h7, 1'b1, ADDR_W'(7), 32'h9, 1'b0, f);
        chk("rw_fired", 32'(f), 32'h1);
        drain("drain_rw1");
        read(32'h7, 1'b0);
        drain("drain_rw2");

        // Load port blocked while a request is outstanding
        read(32'h3, 1'b0);
        chk("ld_block", 32'(wr_rdy), 32'h0);
        drain("drain_ld");
        chk("ld_unblock", 32'(wr_rdy), 32'h1);

        // Reset mid-flight
        for (int i = 0; i < 3; i++) read(32'(i), 1'b0);
        rst = 1'b1;
        exp_q.delete();
        idle(1'b0);
        rst = 1'b0;
        chk("mid_rst_res_rdy", 32'(res_rdy), 32'h0);
        chk("mid_rst_req_rdy", 32'(req_rdy), 32'h1);
        chk("mid_rst_wr_rdy", 32'(wr_rdy), 32'h1);
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            chk("no_stale", 32'(res_rdy), 32'h0);
        end
        for (int i = 0; i < 4; i++) read(32'(i), 1'b1);
        drain("drain_rst");

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            a = ADDR_W'($urandom_range(0, 15));
            v = ($urandom & 32'hFFFF_FC00) | 32'(a);
            step(($urandom % 4) != 0, v,
                 ($urandom % 8) == 0, ADDR_W'($urandom_range(0, 15)), $urandom,
                 ($urandom % 10) < 7, f);
        end
        drain("drain_rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
